// File: rtl/psubsb_seq.sv
// Packed saturating nibble add/subtract, one shared 4-bit lane datapath
// stepped over four cycles under a start/busy/done handshake.

module psubsb_lane (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       op_sub,
  output logic [3:0] res,
  output logic       sat
);
  logic [4:0] a5, b5, r;

  always_comb begin
    a5  = {a[3], a};
    b5  = {b[3], b};
    r   = a5 + (op_sub ? ~b5 : b5) + {4'b0000, op_sub};
    res = r[3:0];
    sat = 1'b0;
    // Operands span [-8,7], so the 5-bit result never wraps; bits 4:3 disagreeing
    // means the value left the 4-bit signed range.
    if (!r[4] && r[3]) begin
      res = 4'b0111;
      sat = 1'b1;
    end else if (r[4] && !r[3]) begin
      res = 4'b1000;
      sat = 1'b1;
    end
  end
endmodule

module psubsb_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_sub,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Sum,
  output logic [3:0]  sat_flags
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [3:0][3:0] a;
    logic [3:0][3:0] b;
    logic            sub;
  } opnd_t;

  state_t          state, state_nxt;
  opnd_t           opnd;
  logic [1:0]      cnt;
  logic [3:0][3:0] sh_res;
  logic [3:0]      sh_sat;
  logic [3:0]      lane_res;
  logic            lane_sat;
  logic            accept;

  psubsb_lane u_lane (
    .a      (opnd.a[cnt]),
    .b      (opnd.b[cnt]),
    .op_sub (opnd.sub),
    .res    (lane_res),
    .sat    (lane_sat)
  );

  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      opnd      <= '0;
      cnt       <= '0;
      sh_res    <= '0;
      sh_sat    <= '0;
      Sum       <= '0;
      sat_flags <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        opnd.a   <= A;
        opnd.b   <= B;
        opnd.sub <= op_sub;
        cnt      <= '0;
      end else if (state == RUN) begin
        sh_res[cnt] <= lane_res;
        sh_sat[cnt] <= lane_sat;
        cnt         <= cnt + 2'd1;
        // Lane 3 bypasses the shadow so the result publishes on this same edge.
        if (cnt == 2'd3) begin
          Sum       <= {lane_res, sh_res[2:0]};
          sat_flags <= {lane_sat, sh_sat[2:0]};
        end
      end
    end
  end
endmodule

// File: tb/tb_psubsb_seq.sv
// Scoreboard bench for psubsb_seq: directed plus random operations checked
// against an integer-arithmetic reference model.

module tb_psubsb_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_sub;
  logic [15:0] A, B;
  logic        busy, done;
  logic [15:0] Sum;
  logic [3:0]  sat_flags;

  psubsb_seq dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .A(A), .B(B),
    .busy(busy), .done(done), .Sum(Sum), .sat_flags(sat_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic [3:0]  flags;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic op, output logic [15:0] s,
                                output logic [3:0] f);
    s = '0;
    f = '0;
    for (int k = 0; k < 4; k++) begin
      int ai, bi, r;
      logic [31:0] rv;
      ai = $signed(a[4*k +: 4]);
      bi = $signed(b[4*k +: 4]);
      r  = op ? ai - bi : ai + bi;
      if (r > 7) begin r = 7; f[k] = 1'b1; end
      else if (r < -8) begin r = -8; f[k] = 1'b1; end
      rv = r;
      s[4*k +: 4] = rv[3:0];
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) begin
        tests++; fails++;
        $display("FAIL busy_done_overlap: busy=%b done=%b at cyc %0d", busy, done, cyc);
      end
      if (done) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: done=1 at cyc %0d with nothing pending", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sum", 32'(Sum), 32'(e.sum));
          check("sat_flags", 32'(sat_flags), 32'(e.flags));
          check("done_latency", cyc, e.cyc);
        end
      end
    end
  end

  // Drive at a negedge; done is expected at the negedge 5 cycles later.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic op);
    exp_t e;
    A = a; B = b; op_sub = op; start = 1'b1;
    model(a, b, op, e.sum, e.flags);
    e.cyc = cyc + 5;
    q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL timeout: %0d results still pending after %0d cycles", q.size(), budget);
      q.delete();
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic op);
    issue(a, b, op);
    @(negedge clk);
    start = 1'b0;
    wait_drain(12);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] s1, s2;
    logic [3:0]  f1, f2;
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(Sum), 32'd0);
    check("rst_flags", 32'(sat_flags), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 1'b0);
    run_op(16'h7777, 16'h1111, 1'b0);
    run_op(16'h8000, 16'h1000, 1'b1);
    run_op(16'h0000, 16'h0008, 1'b1);
    run_op(16'h00F3, 16'h0021, 1'b1);

    // start pulsed in every RUN cycle with junk operands: must be ignored
    issue(16'h3456, 16'h7F81, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      A = 16'($urandom); B = 16'($urandom); op_sub = 1'($urandom);
      start = 1'b1;
      if (busy) begin @(negedge clk); start = 1'b0; end
    end
    start = 1'b0;
    wait_drain(12);
    repeat (3) @(negedge clk);

    // start held high through DONE: back-to-back ops, done 5 cycles apart
    issue(16'h2F5A, 16'h7181, 1'b0);
    model(16'h2F5A, 16'h7181, 1'b0, s1, f1);
    @(negedge clk);
    begin
      exp_t e2;
      A = 16'h9C3E; B = 16'h6D82; op_sub = 1'b1;
      model(A, B, 1'b1, e2.sum, e2.flags);
      e2.cyc = cyc + 9;
      q.push_back(e2);
    end
    repeat (5) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("hold_sum", 32'(Sum), 32'(s1));
    check("hold_flags", 32'(sat_flags), 32'(f1));
    wait_drain(12);
    @(negedge clk);

    // reset during lane 2 of a run
    issue(16'h5A5A, 16'h3C3C, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(Sum), 32'd0);
    check("midrst_flags", 32'(sat_flags), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op(16'h0000, 16'h0008, 1'b1);

    for (int n = 0; n < 40; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    model(16'h8888, 16'h7777, 1'b1, s2, f2);
    run_op(16'h8888, 16'h7777, 1'b1);
    check("final_sum", 32'(Sum), 32'(s2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/psubsb_seq.md
# psubsb_seq

Sequential packed saturating half-byte arithmetic unit for the ALU. It is the subtract-capable, multi-cycle companion to the combinational packed saturating adder. It treats each 16-bit operand as four signed 4-bit lanes and computes either A+B or A−B per lane, saturating to [−8, +7]. It uses a single shared 4-bit lane datapath iterated over four cycles under a start/busy/done handshake, and reports per-lane saturation flags for the flag/writeback logic.

## Interface
- No parameters; lane width (4) and lane count (4) are fixed.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- op_sub  in  1  0 = lane-wise A+B, 1 = lane-wise A−B; latched with start
- A  in  16  operand A, four signed nibbles, lane k = A[4k+3:4k]; latched with start
- B  in  16  operand B, same packing; latched with start
- busy  out  1  high while lanes are being processed
- done  out  1  one-cycle pulse; Sum/sat_flags valid from this cycle
- Sum  out  16  saturated packed result; registered, held until next completion
- sat_flags  out  4  bit k = lane k saturated in last completed operation

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 → latch A, B, op_sub into operand registers; lane counter=0; go to RUN.
- RUN: busy=1. Each cycle processes lane cnt:
  - a = sign-extend lane to 5 bits; b = sign-extend lane to 5 bits.
  - r = a + (op_sub ? ~b : b) + op_sub (5-bit two's complement).
  - r > +7 → 4'b0111, flag=1; r < −8 → 4'b1000, flag=1; else r[3:0], flag=0.
  - Result nibble and flag are written to a shadow register; cnt increments.
  - After lane 3: copy shadow to Sum and sat_flags; go to DONE.
- DONE: done=1, busy=0 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back); otherwise return to IDLE.
- start in RUN is ignored; operands changing during RUN have no effect.
- Sum and sat_flags change only on the RUN→DONE transition or on reset.
- Subtracting B lane = 1000 (−8) is legal. Example: 0 − (−8) = +8, which saturates to 0111.

## Timing
- Reset: state=IDLE, busy=0, done=0, Sum=16'h0000, sat_flags=4'h0, counter/shadow/operand registers cleared.
- Reset has priority over all activity. Asserted mid-RUN, it aborts the operation with no done pulse, and the outputs take their reset values on the next edge.
- Latency: start sampled at edge E0 → busy=1 after E0 → lanes 0..3 at E1..E4 → Sum/sat_flags updated at E4, done=1 and busy=0 for cycle after E4.
- Throughput: one operation per 5 cycles with back-to-back start in DONE.
- busy and done are never high together.

## Test plan
- Add without overflow: A=16'h1234, B=16'h4321, op_sub=0 → done 5 cycles after start, Sum=16'h5555, sat_flags=4'b0000.
- Positive saturation: A=16'h7777, B=16'h1111, op_sub=0 → Sum=16'h7777, sat_flags=4'b1111.
- Negative saturation on subtract: A=16'h8000, B=16'h1000, op_sub=1 → Sum=16'h8000 (lane 3 −8−1 clamps to 1000), sat_flags=4'b1000.
- Subtract −8: A=16'h0000, B=16'h0008, op_sub=1 → Sum=16'h0007, sat_flags=4'b0001. A second case A=16'h00F3, B=16'h0021, op_sub=1 → Sum=16'h00D2, sat_flags=0.
- Handshake: start pulsed again in each RUN cycle → ignored, single done pulse. Start held high through DONE → second operation begins, done pulses 5 cycles apart, and Sum holds the first result until the second completes.
- Reset mid-operation: assert rst during lane 2 of a run → next cycle busy=0, done=0, Sum=0, sat_flags=0, and no done pulse follows. A fresh start then completes normally.
